// File: rtl/gf16sq_inv_seq_pkg.sv
// -----------------------------------------------------------------------------
// gf16sq_inv_seq_pkg
//   Shared definitions for the sequential GF((2^4)^2) inverter.
//   - LAMBDA_DEFAULT : norm constant of the extension polynomial y^2 + y + LAMBDA
//   - GF16_MODULUS   : GF(2^4) reduction polynomial x^4 + x + 1
//   - state_e        : inverter FSM states
//   - gf16_xtime     : multiply-by-x in GF(2^4), the building block for the
//                      shared multiplier and for scaling by a constant
// -----------------------------------------------------------------------------
package gf16sq_inv_seq_pkg;

    localparam logic [3:0] LAMBDA_DEFAULT = 4'b1100;
    localparam logic [4:0] GF16_MODULUS   = 5'b1_0011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELTA = 3'd1,
        S_INV   = 3'd2,
        S_MULH  = 3'd3,
        S_MULL  = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    // a * x mod (x^4 + x + 1): shift left, fold the carried-out x^4 back in.
    function automatic logic [3:0] gf16_xtime(input logic [3:0] a);
        logic [3:0] r;
        r = {a[2:0], 1'b0};
        if (a[3]) begin
            r = r ^ GF16_MODULUS[3:0];
        end
        return r;
    endfunction

endpackage : gf16sq_inv_seq_pkg

// File: rtl/gf16sq_inv_seq_mul.sv
// -----------------------------------------------------------------------------
// gf16_mul
//   Combinational 4x4 multiplier in GF(2^4), modulus x^4 + x + 1.
//   Ports:
//     a_i [3:0] : multiplicand
//     b_i [3:0] : multiplier
//     p_o [3:0] : product a_i * b_i
// -----------------------------------------------------------------------------
module gf16_mul
    import gf16sq_inv_seq_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);

    // Shift-and-add: accumulate a*x^i for every set bit i of b.
    always_comb begin
        logic [3:0] sh;
        sh  = a_i;
        p_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i]) begin
                p_o = p_o ^ sh;
            end
            sh = gf16_xtime(sh);
        end
    end

endmodule : gf16_mul

// File: rtl/gf16sq_inv_seq.sv
// -----------------------------------------------------------------------------
// gf16sq_inv_seq
//   Sequential inverter in GF((2^4)^2) with extension polynomial
//   y^2 + y + LAMBDA over GF(2^4) (x^4 + x + 1). The operand is ah*y + al.
//     d  = LAMBDA*ah^2 ^ ah*al ^ al^2
//     d' = d^-1 (0 maps to 0)
//     ih = ah*d',  il = (ah^al)*d'
//   All three general products go through a single gf16_mul instance, one per
//   FSM state. A zero operand falls out as a zero result because d = 0 and
//   0^-1 = 0.
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : operand offered
//     in_ready  : high only in IDLE; accept on in_valid && in_ready
//     ah, al    : operand high/low nibbles
//     out_valid : result available (OUT state)
//     out_ready : consumer takes result on out_valid && out_ready
//     ih, il    : inverse high/low nibbles, held stable while out_valid
// -----------------------------------------------------------------------------
module gf16sq_inv_seq
    import gf16sq_inv_seq_pkg::*;
#(
    parameter logic [3:0] LAMBDA = LAMBDA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ah,
    input  logic [3:0] al,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ih,
    output logic [3:0] il
);

    // -------------------------------------------------------------------------
    // Local GF(2^4) helpers (linear / table logic, no general multiplier)
    // -------------------------------------------------------------------------

    // Squaring is linear over GF(2): a^2 = a3(x^3+x^2) + a2(x+1) + a1 x^2 + a0.
    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    // Scaling by the elaboration-time constant LAMBDA collapses to XORs.
    function automatic logic [3:0] gf16_scale_lambda(input logic [3:0] a);
        logic [3:0] sh;
        logic [3:0] r;
        sh = a;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            if (LAMBDA[i]) begin
                r = r ^ sh;
            end
            sh = gf16_xtime(sh);
        end
        return r;
    endfunction

    // Multiplicative inverse table; 0 maps to 0 so a zero operand needs no
    // special handling downstream.
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] ah_q, ah_d;
    logic [3:0] al_q, al_d;
    logic [3:0] d_q, d_d;
    logic [3:0] dinv_q, dinv_d;
    logic [3:0] ih_q, ih_d;
    logic [3:0] il_q, il_d;

    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [3:0] mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ah_q    <= '0;
            al_q    <= '0;
            d_q     <= '0;
            dinv_q  <= '0;
            ih_q    <= '0;
            il_q    <= '0;
        end else begin
            state_q <= state_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            d_q     <= d_d;
            dinv_q  <= dinv_d;
            ih_q    <= ih_d;
            il_q    <= il_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shared multiplier and its operand steering. Kept in its own process so
    // the product never feeds back into the block that selects its operands.
    // -------------------------------------------------------------------------
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_DELTA: begin
                mul_a = ah_q;
                mul_b = al_q;
            end
            S_MULH: begin
                mul_a = ah_q;
                mul_b = dinv_q;
            end
            S_MULL: begin
                mul_a = ah_q ^ al_q;
                mul_b = dinv_q;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    gf16_mul u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // -------------------------------------------------------------------------
    // FSM next state and register updates. Each compute state lasts exactly
    // one cycle; only IDLE looks at the input side, only OUT at out_ready.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ah_d      = ah_q;
        al_d      = al_q;
        d_d       = d_q;
        dinv_d    = dinv_q;
        ih_d      = ih_q;
        il_d      = il_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ah_d    = ah;
                    al_d    = al;
                    state_d = S_DELTA;
                end
            end
            S_DELTA: begin
                d_d     = gf16_scale_lambda(gf16_sq(ah_q)) ^ mul_p ^ gf16_sq(al_q);
                state_d = S_INV;
            end
            S_INV: begin
                dinv_d  = gf16_inv(d_q);
                state_d = S_MULH;
            end
            S_MULH: begin
                ih_d    = mul_p;
                state_d = S_MULL;
            end
            S_MULL: begin
                il_d    = mul_p;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ih = ih_q;
    assign il = il_q;

endmodule : gf16sq_inv_seq
